// File: rtl/alu_serial_driver.sv
// Bit-serial sequencer driving an external 1-bit ALU slice across WIDTH cycles.
// Request and result use independent valid/ready handshakes.
module alu_serial_driver #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [3:0]       in_op,
   output logic             slice_a,
   output logic             slice_b,
   output logic             slice_cin,
   output logic [3:0]       slice_op,
   input  logic             slice_result,
   input  logic             slice_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_err
);

   localparam int IW = $clog2(WIDTH);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_NOR = 4'b1100;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, b_reg, result_reg;
   logic [3:0]       op_reg;
   logic [IW-1:0]    idx_reg;
   logic             carry_reg, cout_reg, ovf_reg, zero_reg, err_reg;
   logic             arith, last_bit;

   function automatic logic op_supported(input logic [3:0] op);
      return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
             (op == OP_SUB) || (op == OP_NOR);
   endfunction

   assign arith    = (op_reg == OP_ADD) || (op_reg == OP_SUB);
   assign last_bit = (idx_reg == IW'(WIDTH - 1));

   always_comb begin
      state_next = state_reg;
      slice_a    = 1'b0;
      slice_b    = 1'b0;
      slice_cin  = 1'b0;
      slice_op   = 4'b0000;
      case (state_reg)
         S_IDLE: begin
            if (in_valid)
               state_next = op_supported(in_op) ? S_RUN : S_DONE;
         end
         S_RUN: begin
            case (op_reg)
               OP_AND: begin
                  slice_a  = a_reg[idx_reg];
                  slice_b  = b_reg[idx_reg];
                  slice_op = 4'b0000;
               end
               OP_OR: begin
                  slice_a  = a_reg[idx_reg];
                  slice_b  = b_reg[idx_reg];
                  slice_op = 4'b0001;
               end
               OP_ADD: begin
                  slice_a   = a_reg[idx_reg];
                  slice_b   = b_reg[idx_reg];
                  slice_cin = carry_reg;
                  slice_op  = 4'b0010;
               end
               OP_SUB: begin
                  // a + ~b + 1: the +1 comes from carry_reg preset at accept
                  slice_a   = a_reg[idx_reg];
                  slice_b   = ~b_reg[idx_reg];
                  slice_cin = carry_reg;
                  slice_op  = 4'b0010;
               end
               OP_NOR: begin
                  // De Morgan: ~a & ~b on the slice's AND path
                  slice_a  = ~a_reg[idx_reg];
                  slice_b  = ~b_reg[idx_reg];
                  slice_op = 4'b0000;
               end
               default: ;
            endcase
            if (last_bit)
               state_next = S_DONE;
         end
         S_DONE: begin
            if (out_ready)
               state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= S_IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         op_reg     <= '0;
         result_reg <= '0;
         idx_reg    <= '0;
         carry_reg  <= 1'b0;
         cout_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
         zero_reg   <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            S_IDLE: begin
               if (in_valid) begin
                  a_reg      <= in_a;
                  b_reg      <= in_b;
                  op_reg     <= in_op;
                  result_reg <= '0;
                  idx_reg    <= '0;
                  carry_reg  <= (in_op == OP_SUB);
                  cout_reg   <= 1'b0;
                  ovf_reg    <= 1'b0;
                  zero_reg   <= 1'b0;
                  err_reg    <= !op_supported(in_op);
               end
            end
            S_RUN: begin
               result_reg[idx_reg] <= slice_result;
               if (arith)
                  carry_reg <= slice_cout;
               if (last_bit) begin
                  if (arith) begin
                     cout_reg <= slice_cout;
                     ovf_reg  <= slice_cin ^ slice_cout;
                  end
                  // Lower bits are already final; the MSB arrives this cycle
                  zero_reg <= ({slice_result, result_reg[WIDTH-2:0]} == '0);
               end else begin
                  idx_reg <= idx_reg + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready   = (state_reg == S_IDLE);
   assign out_valid  = (state_reg == S_DONE);
   assign out_result = result_reg;
   assign out_zero   = zero_reg;
   assign out_cout   = cout_reg;
   assign out_ovf    = ovf_reg;
   assign out_err    = err_reg;

endmodule
